// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg
// Shared definitions for the load/store unit and its byte-lane helper:
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 11 is illegal)
//   - FSM state encoding
//   - default data-memory depth in 32-bit words
//   - request_is_error(): classifies a request as misaligned, illegal-size
//     or out-of-range before any memory access is made
package load_store_unit_pkg;

    localparam int unsigned DEFAULT_MEM_WORDS = 128;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // The word index is addr[31:2], so range checking widens it back to
    // 32 bits before comparing against the memory depth.
    function automatic logic request_is_error(input logic [1:0]  size,
                                              input logic [31:0] addr,
                                              input int unsigned mem_words);
        logic misaligned;
        logic out_of_range;
        misaligned   = ((size == SZ_HALF) && addr[0]) ||
                       ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        out_of_range = ({2'b00, addr[31:2]} >= mem_words);
        return (size == SZ_BAD) || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/lsu_byte_lanes.sv
// lsu_byte_lanes
// Purely combinational little-endian lane logic for the load/store unit.
// Ports:
//   word       in  32  memory word (ReadData)
//   wdata      in  32  right-aligned store data
//   size       in   2  access size (size_e)
//   offset     in   2  byte offset addr[1:0]
//   zero_ext   in   1  1 = zero-extend loads, 0 = sign-extend
//   load_data  out 32  selected lane, extended to 32 bits
//   store_word out 32  word with the selected lane(s) replaced by wdata
module lsu_byte_lanes
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        zero_ext,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    // Lane k of a word lives at bits [8k+7:8k]; halfwords use offset[1] only
    // because offset[0] is guaranteed zero for accepted halfword requests.
    function automatic logic [31:0] extract_lane(input logic [31:0] w,
                                                 input size_e       sz,
                                                 input logic [1:0]  off,
                                                 input logic        zx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: r = {{24{~zx & b[7]}}, b};
            SZ_HALF: r = {{16{~zx & h[15]}}, h};
            SZ_WORD: r = w;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Read-modify-write merge: only the addressed lane(s) change, all other
    // bits of the original word pass through untouched.
    function automatic logic [31:0] merge_lanes(input logic [31:0] w,
                                                input logic [31:0] wd,
                                                input size_e       sz,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = w;
        case (sz)
            SZ_BYTE: r[{off, 3'b000} +: 8]     = wd[7:0];
            SZ_HALF: r[{off[1], 4'b0000} +: 16] = wd[15:0];
            SZ_WORD: r = wd;
            default: r = w;
        endcase
        return r;
    endfunction

    assign load_data  = extract_lane(word, size, offset, zero_ext);
    assign store_word = merge_lanes(word, wdata, size, offset);

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator side of a word-indexed data memory. Accepts byte/half/word
// loads and stores on a valid/ready handshake, performs sub-word stores as
// read-modify-write and rejects bad requests without touching memory.
// Ports:
//   Clock, Reset                 clock, async active-high reset
//   req_valid/req_ready          request handshake
//   req_write, req_size,         request kind, size, extension mode,
//   req_unsigned, req_addr,      byte address and right-aligned store data
//   req_wdata
//   resp_valid, resp_rdata,      one-cycle completion with load data / error
//   resp_err
//   Resultado, DadosEscrita,     memory word index, write word and strobes
//   MemRead, MemWrite
//   ReadData                     memory read word (valid at the posedge after
//                                the MemRead negedge)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
)
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] Resultado,
    output logic [31:0] DadosEscrita,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] ReadData
);

    state_e      state;
    logic        cap_write;
    size_e       cap_size;
    logic        cap_zero_ext;
    logic [1:0]  cap_offset;
    logic [31:0] cap_wdata;
    logic [31:0] load_data;
    logic [31:0] store_word;

    // Lane logic always works from the captured request so the datapath
    // inputs can change freely once a request has been accepted.
    lsu_byte_lanes u_lanes (
        .word       (ReadData),
        .wdata      (cap_wdata),
        .size       (cap_size),
        .offset     (cap_offset),
        .zero_ext   (cap_zero_ext),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Strobes decode straight from the state register, so an asynchronous
    // reset drops them immediately and a WRITE cut short never reaches memory.
    assign req_ready = (state == IDLE) && !Reset;
    assign MemRead   = (state == READ);
    assign MemWrite  = (state == WRITE);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            cap_write    <= 1'b0;
            cap_size     <= SZ_BYTE;
            cap_zero_ext <= 1'b0;
            cap_offset   <= 2'b00;
            cap_wdata    <= '0;
            Resultado    <= '0;
            DadosEscrita <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    if (req_valid) begin
                        cap_write    <= req_write;
                        cap_size     <= size_e'(req_size);
                        cap_zero_ext <= req_unsigned;
                        cap_offset   <= req_addr[1:0];
                        cap_wdata    <= req_wdata;
                        if (request_is_error(req_size, req_addr, MEM_WORDS)) begin
                            // Rejected requests complete at once with no strobe.
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            Resultado <= {2'b00, req_addr[31:2]};
                            if (req_write && (req_size == SZ_WORD)) begin
                                DadosEscrita <= req_wdata;
                                state        <= WRITE;
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (cap_write) begin
                        DadosEscrita <= store_word;
                        state        <= WRITE;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit: a negedge-sampling data memory,
// a behavioural reference memory with arithmetic lane rules, directed
// scenarios and a randomized request stream.
module tb_load_store_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] Resultado;
    logic [31:0] DadosEscrita;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData = '0;

    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];

    int checks = 0;
    int passes = 0;

    load_store_unit #(.MEM_WORDS(128)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .Resultado    (Resultado),
        .DadosEscrita (DadosEscrita),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .ReadData     (ReadData)
    );

    always #5 Clock = ~Clock;

    // Data memory: samples strobes on the falling edge.
    always @(negedge Clock) begin
        if (MemRead && (Resultado < 32'd128)) ReadData <= mem[Resultado[6:0]];
        if (MemWrite && (Resultado < 32'd128)) mem[Resultado[6:0]] <= DadosEscrita;
    end

    // ---------------- reference model ----------------
    function automatic logic ref_err(input int sz, input logic [31:0] addr);
        return (sz == 3) || (sz == 1 && addr % 2 != 0) ||
               (sz == 2 && addr % 4 != 0) || (addr / 4 >= 128);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int sz,
                                             input int off, input logic zx);
        logic [31:0] v;
        if (sz == 0) begin
            v = (w >> (8 * off)) % 256;
            if (!zx && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = (w >> (16 * (off / 2))) % 65536;
            if (!zx && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] wd,
                                              input int sz, input int off);
        logic [31:0] mask;
        int sh;
        if (sz == 0) begin
            sh = 8 * off;
            mask = 32'hFF << sh;
            return (w & ~mask) | ((wd % 256) << sh);
        end else if (sz == 1) begin
            sh = 16 * (off / 2);
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((wd % 65536) << sh);
        end
        return wd;
    endfunction

    // ---------------- driver (no comparisons) ----------------
    // Issues one request and observes it to completion. lat is the number of
    // edges after the accepting edge until resp_valid is seen (-1 = never).
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic zx,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int n_rd, output int n_wr, output logic [31:0] wr_word,
                           output logic [31:0] strobe_idx, output logic idx_stable,
                           output logic both);
        int k;
        logic got;
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge Clock); #1;
            k++;
        end
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_unsigned = zx; req_addr = addr; req_wdata = wd;
        @(posedge Clock); #1;
        // Scramble fields once accepted; the unit must use its captured copy.
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = -1; n_rd = 0; n_wr = 0; both = 1'b0; idx_stable = 1'b1;
        strobe_idx = '0; wr_word = '0; rdata = '0; err = 1'b0; got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (MemRead || MemWrite) begin
                if (n_rd + n_wr == 0) strobe_idx = Resultado;
                else if (Resultado !== strobe_idx) idx_stable = 1'b0;
            end
            if (MemRead) n_rd++;
            if (MemWrite) begin
                n_wr++;
                wr_word = DadosEscrita;
            end
            if (MemRead && MemWrite) both = 1'b1;
            if (resp_valid) begin
                got = 1'b1; lat = i; rdata = resp_rdata; err = resp_err;
            end else begin
                @(posedge Clock); #1;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (req_ready !== 1'b0) $display("[TB] FAIL rst_ready: got %b want 0", req_ready); else passes++;
        checks++; if ({MemRead, MemWrite, resp_valid, resp_err} !== 4'b0000)
            $display("[TB] FAIL rst_flags: got %b want 0000", {MemRead, MemWrite, resp_valid, resp_err}); else passes++;
        checks++; if ({Resultado, DadosEscrita, resp_rdata} !== 96'd0)
            $display("[TB] FAIL rst_data: got %h %h %h want 0", Resultado, DadosEscrita, resp_rdata); else passes++;
        #2 Reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("[TB] FAIL rst_release_ready: got %b want 1", req_ready); else passes++;
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd, ww, idx; logic err, st, both; int lat, nr, nw;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, err, lat, nr, nw, ww, idx, st, both);
        ref_mem[4] = 32'hDEADBEEF;
        checks++; if (err !== 1'b0 || lat != 1) $display("[TB] FAIL ws_resp: got err=%b lat=%0d want err=0 lat=1", err, lat); else passes++;
        checks++; if (nr != 0 || nw != 1) $display("[TB] FAIL ws_strobes: got rd=%0d wr=%0d want 0/1", nr, nw); else passes++;
        checks++; if (idx !== 32'd4 || ww !== 32'hDEADBEEF) $display("[TB] FAIL ws_port: got idx=%0d data=%h want 4 deadbeef", idx, ww); else passes++;
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, nr, nw, ww, idx, st, both);
        checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) $display("[TB] FAIL wl_data: got %h err=%b want deadbeef err=0", rd, err); else passes++;
        checks++; if (lat != 1 || nr != 1 || nw != 0) $display("[TB] FAIL wl_timing: got lat=%0d rd=%0d wr=%0d want 1/1/0", lat, nr, nw); else passes++;
    endtask

    task automatic test_byte_rmw();
        logic [31:0] rd, ww, idx; logic err, st, both; int lat, nr, nw;
        run_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344, rd, err, lat, nr, nw, ww, idx, st, both);
        run_req(1'b1, 2'b00, 1'b0, 32'h6, 32'hFFFFFFAA, rd, err, lat, nr, nw, ww, idx, st, both);
        ref_mem[1] = 32'h11AA3344;
        checks++; if (lat != 2 || err !== 1'b0) $display("[TB] FAIL rmw_lat: got lat=%0d err=%b want 2 0", lat, err); else passes++;
        checks++; if (nr != 1 || nw != 1 || both !== 1'b0) $display("[TB] FAIL rmw_strobes: got rd=%0d wr=%0d both=%b want 1/1/0", nr, nw, both); else passes++;
        checks++; if (ww !== 32'h11AA3344 || idx !== 32'd1 || st !== 1'b1)
            $display("[TB] FAIL rmw_word: got %h idx=%0d stable=%b want 11aa3344 1 1", ww, idx, st); else passes++;
        checks++; if (mem[1] !== 32'h11AA3344) $display("[TB] FAIL rmw_mem: got %h want 11aa3344", mem[1]); else passes++;
        checks++; if (rd !== 32'h0) $display("[TB] FAIL rmw_rdata: got %h want 0", rd); else passes++;
    endtask

    task automatic test_extension();
        logic [31:0] rd, ww, idx; logic err, st, both; int lat, nr, nw;
        run_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h80FF7F01, rd, err, lat, nr, nw, ww, idx, st, both);
        ref_mem[2] = 32'h80FF7F01;
        run_req(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, rd, err, lat, nr, nw, ww, idx, st, both);
        checks++; if (rd !== 32'hFFFF80FF) $display("[TB] FAIL ext_half_s: got %h want ffff80ff", rd); else passes++;
        run_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, rd, err, lat, nr, nw, ww, idx, st, both);
        checks++; if (rd !== 32'h0000007F) $display("[TB] FAIL ext_byte_u: got %h want 0000007f", rd); else passes++;
        run_req(1'b0, 2'b00, 1'b0, 32'h8, 32'h0, rd, err, lat, nr, nw, ww, idx, st, both);
        checks++; if (rd !== 32'h00000001) $display("[TB] FAIL ext_byte_s: got %h want 00000001", rd); else passes++;
        run_req(1'b0, 2'b00, 1'b0, 32'hB, 32'h0, rd, err, lat, nr, nw, ww, idx, st, both);
        checks++; if (rd !== 32'hFFFFFF80) $display("[TB] FAIL ext_byte_s3: got %h want ffffff80", rd); else passes++;
    endtask

    task automatic test_errors();
        logic [31:0] rd, ww, idx; logic err, st, both; int lat, nr, nw;
        logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] addrs [4] = '{32'h2, 32'h3, 32'h0, 32'h200};
        logic        wrs   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_req(wrs[i], sizes[i], 1'b0, addrs[i], 32'hCAFEF00D, rd, err, lat, nr, nw, ww, idx, st, both);
            checks++; if (err !== 1'b1 || lat != 0)
                $display("[TB] FAIL err_resp[%0d]: got err=%b lat=%0d want 1 0", i, err, lat); else passes++;
            checks++; if (nr + nw != 0 || rd !== 32'h0)
                $display("[TB] FAIL err_quiet[%0d]: got strobes=%0d rdata=%h want 0 0", i, nr + nw, rd); else passes++;
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, ww, idx, addr, wd, exp_rd; logic err, st, both, wr, zx, exp_err;
        int lat, nr, nw, sz, off, w, exp_lat, bad;
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom); zx = 1'($urandom); wd = $urandom;
            sz = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else addr = $urandom_range(0, 135) * 4 + $urandom_range(0, 3);
            off = int'(addr % 4); w = int'((addr / 4) % 128);
            exp_err = ref_err(sz, addr);
            exp_rd = (exp_err || wr) ? 32'h0 : ref_load(ref_mem[w], sz, off, zx);
            exp_lat = exp_err ? 0 : (wr && sz != 2) ? 2 : 1;
            run_req(wr, 2'(sz), zx, addr, wd, rd, err, lat, nr, nw, ww, idx, st, both);
            if (!exp_err && wr) ref_mem[w] = ref_store(ref_mem[w], wd, sz, off);
            checks++; if (err !== exp_err || rd !== exp_rd)
                $display("[TB] FAIL rnd_resp[%0d]: got err=%b rdata=%h want err=%b rdata=%h", n, err, rd, exp_err, exp_rd); else passes++;
            checks++; if (lat != exp_lat) $display("[TB] FAIL rnd_lat[%0d]: got %0d want %0d", n, lat, exp_lat); else passes++;
            checks++; if (nr != ((exp_err || (wr && sz == 2)) ? 0 : 1) || nw != ((!exp_err && wr) ? 1 : 0) || both || !st)
                $display("[TB] FAIL rnd_strobes[%0d]: got rd=%0d wr=%0d both=%b stable=%b", n, nr, nw, both, st); else passes++;
        end
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++; if (bad != 0) $display("[TB] FAIL rnd_mem: got %0d differing words want 0", bad); else passes++;
    endtask

    task automatic test_reset_during_write();
        logic [31:0] rd, ww, idx; logic err, st, both, saw; int lat, nr, nw, k;
        run_req(1'b1, 2'b10, 1'b0, 32'hC, 32'h55555555, rd, err, lat, nr, nw, ww, idx, st, both);
        ref_mem[3] = 32'h55555555;
        k = 0;
        while (!req_ready && k < 20) begin @(posedge Clock); #1; k++; end
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'hC; req_wdata = 32'h000000AA;
        @(posedge Clock); #1;
        req_valid = 1'b0;
        @(posedge Clock); #1;
        checks++; if (MemWrite !== 1'b1) $display("[TB] FAIL rdw_in_write: got %b want 1", MemWrite); else passes++;
        Reset = 1'b1;
        #1;
        checks++; if (MemWrite !== 1'b0 || MemRead !== 1'b0 || resp_valid !== 1'b0)
            $display("[TB] FAIL rdw_drop: got wr=%b rd=%b rv=%b want 0", MemWrite, MemRead, resp_valid); else passes++;
        #6 Reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("[TB] FAIL rdw_ready: got %b want 1", req_ready); else passes++;
        checks++; if (mem[3] !== ref_mem[3]) $display("[TB] FAIL rdw_mem: got %h want %h", mem[3], ref_mem[3]); else passes++;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge Clock); #1; if (resp_valid) saw = 1'b1; end
        checks++; if (saw !== 1'b0) $display("[TB] FAIL rdw_no_resp: got %b want 0", saw); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ww, wd, new_word, exp_b, rd_b; int w, a_done, ready_at, b_lat, k;
        w = int'($urandom_range(0, 127)); wd = $urandom;
        new_word = ref_store(ref_mem[w], wd, 1, 2);
        exp_b = ref_load(new_word, 1, 2, 1'b0);
        k = 0;
        while (!req_ready && k < 20) begin @(posedge Clock); #1; k++; end
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'(w * 4 + 2); req_wdata = wd;
        @(posedge Clock); #1;
        a_done = -1; ready_at = -1; ww = '0;
        for (int i = 0; i < 12 && ready_at < 0; i++) begin
            if (MemWrite) ww = DadosEscrita;
            if (resp_valid && a_done < 0) a_done = i;
            if (req_ready) begin
                ready_at = i;
                req_write = 1'b0; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 32'(w * 4 + 2);
            end else begin
                req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
            @(posedge Clock); #1;
        end
        req_valid = 1'b0;
        ref_mem[w] = new_word;
        b_lat = -1; rd_b = '0;
        for (int i = 0; i < 8 && b_lat < 0; i++) begin
            if (resp_valid) begin b_lat = i; rd_b = resp_rdata; end
            else begin @(posedge Clock); #1; end
        end
        checks++; if (a_done != 2 || ready_at != 3)
            $display("[TB] FAIL b2b_timing: got done=%0d ready=%0d want 2 3", a_done, ready_at); else passes++;
        checks++; if (ww !== new_word) $display("[TB] FAIL b2b_merge: got %h want %h", ww, new_word); else passes++;
        checks++; if (b_lat != 1 || rd_b !== exp_b)
            $display("[TB] FAIL b2b_second: got lat=%0d rdata=%h want 1 %h", b_lat, rd_b, exp_b); else passes++;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        #1;
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_extension();
        test_errors();
        test_random();
        test_reset_during_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run still active at 100000, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface. It accepts byte, halfword and word load/store requests from the datapath on a valid/ready handshake, with byte addresses. It drives the data memory's word-indexed `Resultado`/`DadosEscrita`/`MemRead`/`MemWrite` port and consumes `ReadData`. Sub-word stores are done as read-modify-write. Loads are extracted and extended. Misaligned, illegal-size and out-of-range requests are rejected without touching memory.

## Interface
- `MEM_WORDS`, 128: number of 32-bit words in the data memory. Valid word indices are 0..MEM_WORDS-1.
- `Clock`  in  1  single clock. All state updates on posedge. The memory samples on negedge.
- `Reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept. Equals (state==IDLE) && !Reset.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only. 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result. 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`. Flags misaligned, illegal-size or out-of-range requests.
- `Resultado`  out  32  memory word index = `req_addr[31:2]`.
- `DadosEscrita`  out  32  memory write word.
- `MemRead`  out  1  memory read strobe.
- `MemWrite`  out  1  memory write strobe.
- `ReadData`  in  32  memory read word. Valid at the posedge following a `MemRead` negedge.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE → DONE: on `req_valid`, when the request is an error. No strobe is raised and `resp_err` is 1.
- IDLE → READ: on `req_valid` for a load or a sub-word store.
- IDLE → WRITE: on `req_valid` for a word store.
- READ → DONE for a load. READ → WRITE for a sub-word store. WRITE → DONE. DONE → IDLE.
- Error conditions:
  - size 11;
  - half with `addr[0]`≠0;
  - word with `addr[1:0]`≠0;
  - `addr[31:2]` ≥ MEM_WORDS.
- Request fields are captured on the accepting edge and held until DONE. Inputs are ignored while `req_ready`=0.
- Little-endian byte lanes: offset `addr[1:0]`=k selects bits [8k+7:8k]. Halfword offset 0 → [15:0], offset 2 → [31:16].
- Load: the selected lane is extended per `req_unsigned` to 32 bits.
- Sub-word store: the captured `ReadData` word has only the selected lane(s) replaced by `req_wdata` low bits. The other lanes are preserved bit-exact.
- Word store: `DadosEscrita` = `req_wdata`.
- Strobes:
  - `MemRead`=1 exactly in READ.
  - `MemWrite`=1 exactly in WRITE.
  - Never both high.
  - `Resultado` is held stable throughout READ/WRITE.

## Timing
- All outputs are registered or decoded from the state register. No combinational path from `req_*` to memory outputs.
- Acceptance edge E0 (`req_valid`&&`req_ready`):
  - Load: READ during E0–E1, memory reads at the intervening negedge, `ReadData` captured at E1, `resp_valid` in E1–E2. Latency 2 edges.
  - Word store: WRITE E0–E1, `resp_valid` E1–E2.
  - Sub-word store: READ E0–E1, WRITE E1–E2, `resp_valid` E2–E3.
  - Error: `resp_valid`/`resp_err` E0–E1.
- Next request accepted earliest at the edge ending DONE+IDLE, i.e. one request per (latency+1) cycles.
- Reset values: state IDLE; `MemRead`, `MemWrite`, `resp_valid`, `resp_err` = 0; `Resultado`, `DadosEscrita`, `resp_rdata` = 0; `req_ready`=0 while `Reset` is high and 1 afterwards.
- Reset mid-operation: strobes drop immediately and asynchronously. The in-flight request is discarded with no `resp_valid`. If reset asserts before the negedge of a WRITE cycle, memory is not written.

## Structure
- Shared package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state encoding, default MEM_WORDS.
- Sub-module `lsu_byte_lanes` (combinational), with two functions:
  - extraction with sign/zero extension;
  - store-lane merge from (word, wdata, size, offset).
- The FSM and registers stay in `load_store_unit`.

## Test plan
- Word store then load: store 0xDEADBEEF @0x10 → `MemWrite`=1 one cycle with `Resultado`=4. Load @0x10 returns 0xDEADBEEF, `resp_err`=0, 2-edge latency.
- Byte store RMW: mem[1]=0x11223344, byte store 0xAA @0x06 → one READ then one WRITE with `DadosEscrita`=0x11AA3344. `resp_valid` at E2.
- Extension: mem[2]=0x80FF7F01. Signed half load @0x0A → 0xFFFF80FF. Unsigned byte load @0x09 → 0x0000007F. Signed byte @0x08 → 0x00000001.
- Errors: word load @0x02, half @0x03, size 11, word @0x200 (index 128) → `resp_err`=1 in E0–E1, no strobe ever high.
- Reset during WRITE before negedge: mem[3]=0x55555555, byte store @0x0C, Reset in WRITE → no `resp_valid`, mem[3] unchanged, `req_ready`=1 after release.
- Back-pressure: `req_valid` held during a sub-word store → second request accepted only after DONE; captured fields are unaffected by input changes while busy.
